// File: rtl/filt_seq_ctrl.sv
// filt_seq_ctrl: sequences one pass of a coefficient-ROM FIR band filter for
// every stereo sample taken from the circular sample queue.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   smpl_valid   one-cycle pulse, a new sample was written to the queue
//   q_full       queue holds a full filter window
//   clr_ovr      synchronous clear of the sticky overrun flag
//   lft_filt     band filter left output (meaningful at the capture tap)
//   rght_filt    band filter right output (meaningful at the capture tap)
//   sequencing   filter enable; its rising edge restarts the filter pass
//   q_rd_en      queue read strobe, one sample per cycle during a pass
//   lft_out      captured left result, held until the next capture
//   rght_out     captured right result, held until the next capture
//   out_valid    one-cycle pulse in the cycle after capture
//   busy         high while a pass is running
//   overrun      sticky, a sample arrived while one was already pending
//
// state | meaning
// IDLE  | waiting for a sample (new or pending) with the queue full
// RUN   | filter pass in progress, tap_cnt counts cycles since S0
// DONE  | result captured, out_valid high, forces sequencing low
module filt_seq_ctrl #(
  parameter int CAPTURE_TAP = 1022,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_valid,
  input  logic        q_full,
  input  logic        clr_ovr,
  input  logic [15:0] lft_filt,
  input  logic [15:0] rght_filt,
  output logic        sequencing,
  output logic        q_rd_en,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Filter address k is presented in cycle S(k+1), so the capture tap is
  // reached when the cycle counter equals CAPTURE_TAP+1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CAPTURE_TAP + 1);

  state_t           state;
  logic [CNT_W-1:0] tap_cnt;
  logic             pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      pending    <= 1'b0;
      sequencing <= 1'b0;
      q_rd_en    <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
    end else begin
      out_valid <= 1'b0;
      // Cleared here first so that an overrun set below in the same cycle wins.
      if (clr_ovr) overrun <= 1'b0;

      case (state)
        IDLE: begin
          // A sample arriving while the queue is still prefilling is dropped.
          if ((smpl_valid | pending) & q_full) begin
            state      <= RUN;
            tap_cnt    <= '0;
            pending    <= 1'b0;
            sequencing <= 1'b1;
            q_rd_en    <= 1'b1;
            busy       <= 1'b1;
          end
        end

        RUN: begin
          if (smpl_valid) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
          if (tap_cnt == LAST_CNT) begin
            lft_out    <= lft_filt;
            rght_out   <= rght_filt;
            state      <= DONE;
            sequencing <= 1'b0;
            q_rd_en    <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
          end
        end

        DONE: begin
          if (smpl_valid) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          sequencing <= 1'b0;
          q_rd_en    <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
